// File: rtl/rom_load_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rom_load_pkg
// Shared definitions for the ROM load sequencer:
//   state_e     - sequencer states (EMPTY, LOAD, WRITE, HOLD, RUN)
//   region_hit  - half-open range test used by the region decoder
// -----------------------------------------------------------------------------
package rom_load_pkg;

    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4
    } state_e;

    // Widest region address the helper supports; callers zero-extend into it.
    localparam int ADDR_MAX_W = 32;

    // True when base <= addr < base + size. The limit is one bit wider than
    // the operands so a region ending exactly at the top of the address
    // space does not wrap to zero.
    function automatic logic region_hit(
        input logic [ADDR_MAX_W-1:0] addr,
        input logic [ADDR_MAX_W-1:0] base,
        input logic [ADDR_MAX_W-1:0] size
    );
        logic [ADDR_MAX_W:0] limit;
        limit      = {1'b0, base} + {1'b0, size};
        region_hit = (addr >= base) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/rom_load_sequencer_decode.sv
// -----------------------------------------------------------------------------
// rom_region_decode
// Combinational region decoder. The lowest-index region containing addr wins.
//   addr        in   AW    download byte address
//   hit         out  NREG  one-hot winning region (all zero when none)
//   any_hit     out  1     some region contains addr
//   local_addr  out  AW    addr minus the winning region's base
// -----------------------------------------------------------------------------
module rom_region_decode
    import rom_load_pkg::*;
#(
    parameter int                 AW       = 17,
    parameter int                 NREG     = 4,
    parameter logic [AW*NREG-1:0] REG_BASE = '0,
    parameter logic [AW*NREG-1:0] REG_SIZE = '0
) (
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] hit,
    output logic            any_hit,
    output logic [AW-1:0]   local_addr
);

    // Priority scan: once a region matches, later regions are masked off.
    always_comb begin
        logic match;
        hit        = '0;
        any_hit    = 1'b0;
        local_addr = '0;
        match      = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            match      = !any_hit &&
                         region_hit(ADDR_MAX_W'(addr),
                                    ADDR_MAX_W'(REG_BASE[AW*i +: AW]),
                                    ADDR_MAX_W'(REG_SIZE[AW*i +: AW]));
            hit[i]     = match;
            local_addr = match ? (addr - REG_BASE[AW*i +: AW]) : local_addr;
            any_hit    = any_hit | match;
        end
    end

endmodule

// File: rtl/rom_load_sequencer.sv
// -----------------------------------------------------------------------------
// rom_load_sequencer
// Steers HPS ioctl download bytes into per-region ROM write ports, paces the
// writes with ioctl_wait, and holds the game core in reset for the download
// plus a fixed post-load stretch.
//   clk_sys, reset       clock, synchronous active-high reset
//   ioctl_download/wr/addr/dout   HPS download interface (inputs)
//   ioctl_wait           backpressure to HPS
//   mem_we/addr/din      one-hot region write port, held WR_CYC clocks
//   core_reset           game core reset (low only in RUN)
//   load_done            a complete load finished since reset
//   byte_count, checksum statistics of the current/last load
//   err_range, err_ovf   sticky drop flags for the current/last load
// -----------------------------------------------------------------------------
module rom_load_sequencer
    import rom_load_pkg::*;
#(
    parameter int                 AW       = 17,
    parameter int                 NREG     = 4,
    parameter logic [AW*NREG-1:0] REG_BASE = '0,
    parameter logic [AW*NREG-1:0] REG_SIZE = '0,
    parameter int                 WR_CYC   = 2,
    parameter int                 HOLD_CYC = 16
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            ioctl_download,
    input  logic            ioctl_wr,
    input  logic [24:0]     ioctl_addr,
    input  logic [7:0]      ioctl_dout,
    output logic            ioctl_wait,
    output logic [NREG-1:0] mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [7:0]      mem_din,
    output logic            core_reset,
    output logic            load_done,
    output logic [AW:0]     byte_count,
    output logic [15:0]     checksum,
    output logic            err_range,
    output logic            err_ovf
);

    localparam logic [3:0]  WR_LAST   = 4'(WR_CYC - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);
    localparam logic [AW:0] COUNT_MAX = {1'b1, {AW{1'b0}}};

    state_e          state_q,      state_d;
    logic            skid_full_q,  skid_full_d;
    logic [AW-1:0]   skid_addr_q,  skid_addr_d;
    logic [7:0]      skid_data_q,  skid_data_d;
    logic [3:0]      wr_cnt_q,     wr_cnt_d;
    logic [15:0]     hold_cnt_q,   hold_cnt_d;
    logic [NREG-1:0] mem_we_q,     mem_we_d;
    logic [AW-1:0]   mem_addr_q,   mem_addr_d;
    logic [7:0]      mem_din_q,    mem_din_d;
    logic            ioctl_wait_q, ioctl_wait_d;
    logic            core_reset_q, core_reset_d;
    logic            load_done_q,  load_done_d;
    logic [AW:0]     byte_count_q, byte_count_d;
    logic [15:0]     checksum_q,   checksum_d;
    logic            err_range_q,  err_range_d;
    logic            err_ovf_q,    err_ovf_d;

    logic [NREG-1:0] dec_hit_s;
    logic            dec_any_s;
    logic [AW-1:0]   dec_local_s;
    logic            wr_last_s;
    logic            pop_s;
    logic            accepting_s;
    logic            unused_addr_s;

    // Address bits above AW play no part in region selection.
    assign unused_addr_s = ^ioctl_addr[24:AW];

    rom_region_decode #(
        .AW       (AW),
        .NREG     (NREG),
        .REG_BASE (REG_BASE),
        .REG_SIZE (REG_SIZE)
    ) u_decode (
        .addr       (skid_addr_q),
        .hit        (dec_hit_s),
        .any_hit    (dec_any_s),
        .local_addr (dec_local_s)
    );

    assign wr_last_s   = (wr_cnt_q == WR_LAST);
    assign accepting_s = (state_q == ST_LOAD) || (state_q == ST_WRITE);
    // The skid drains from LOAD, or back-to-back on a write's final clock so
    // a queued byte starts its write without an idle LOAD clock in between.
    assign pop_s       = skid_full_q &&
                         ((state_q == ST_LOAD) || ((state_q == ST_WRITE) && wr_last_s));

    // Next-state, skid, write port and statistics logic.
    always_comb begin
        state_d      = state_q;
        skid_full_d  = skid_full_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        wr_cnt_d     = wr_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        load_done_d  = load_done_q;
        byte_count_d = byte_count_q;
        checksum_d   = checksum_q;
        err_range_d  = err_range_q;
        err_ovf_d    = err_ovf_q;

        case (state_q)
            ST_EMPTY, ST_RUN: begin
                if (ioctl_download) begin
                    state_d      = ST_LOAD;
                    byte_count_d = '0;
                    checksum_d   = 16'h0000;
                    err_range_d  = 1'b0;
                    err_ovf_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (pop_s && dec_any_s) begin
                    state_d = ST_WRITE;
                end else if (!ioctl_download && !skid_full_q && !ioctl_wr) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = 16'h0000;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_WRITE: begin
                if (!wr_last_s) begin
                    wr_cnt_d = wr_cnt_q + 4'd1;
                end else if (pop_s && dec_any_s) begin
                    // Chained write; the pop block below reloads the port.
                    state_d = ST_WRITE;
                end else if (skid_full_q || ioctl_download || ioctl_wr) begin
                    state_d  = ST_LOAD;
                    mem_we_d = '0;
                end else begin
                    // Download is over and nothing is queued: start the stretch
                    // on the same edge the write ends.
                    state_d    = ST_HOLD;
                    hold_cnt_d = 16'h0000;
                    mem_we_d   = '0;
                end
            end
            ST_HOLD: begin
                if (ioctl_download) begin
                    state_d      = ST_LOAD;
                    byte_count_d = '0;
                    checksum_d   = 16'h0000;
                    err_range_d  = 1'b0;
                    err_ovf_d    = 1'b0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = ST_RUN;
                    load_done_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Drain the skid: launch a write or drop an out-of-range byte.
        if (pop_s) begin
            skid_full_d = 1'b0;
            if (dec_any_s) begin
                mem_we_d   = dec_hit_s;
                mem_addr_d = dec_local_s;
                mem_din_d  = skid_data_q;
                wr_cnt_d   = 4'd0;
                checksum_d = checksum_q + {8'h00, skid_data_q};
                if (byte_count_q != COUNT_MAX) begin
                    byte_count_d = byte_count_q + {{AW{1'b0}}, 1'b1};
                end else begin
                    byte_count_d = byte_count_q;
                end
            end else begin
                err_range_d = 1'b1;
            end
        end else begin
            skid_full_d = skid_full_q;
        end

        // Capture a strobe; a slot freed by this clock's pop is reusable.
        if (accepting_s && ioctl_wr) begin
            if (!skid_full_q || pop_s) begin
                skid_full_d = 1'b1;
                skid_addr_d = ioctl_addr[AW-1:0];
                skid_data_d = ioctl_dout;
            end else begin
                err_ovf_d = 1'b1;
            end
        end else begin
            skid_addr_d = skid_addr_d;
        end

        // Registered versions of the status outputs, from next-state values.
        ioctl_wait_d = skid_full_d || (state_d == ST_WRITE);
        core_reset_d = (state_d != ST_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            skid_full_q  <= 1'b0;
            skid_addr_q  <= '0;
            skid_data_q  <= 8'h00;
            wr_cnt_q     <= 4'd0;
            hold_cnt_q   <= 16'h0000;
            mem_we_q     <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= 8'h00;
            ioctl_wait_q <= 1'b0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            byte_count_q <= '0;
            checksum_q   <= 16'h0000;
            err_range_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            skid_full_q  <= skid_full_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
            wr_cnt_q     <= wr_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            ioctl_wait_q <= ioctl_wait_d;
            core_reset_q <= core_reset_d;
            load_done_q  <= load_done_d;
            byte_count_q <= byte_count_d;
            checksum_q   <= checksum_d;
            err_range_q  <= err_range_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    assign ioctl_wait = ioctl_wait_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;
    assign err_range  = err_range_q;
    assign err_ovf    = err_ovf_q;

endmodule
